// File: rtl/stepper_pkg.sv
// Shared types and defaults for the multi-channel stepper pulse generator.
package stepper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW
    } ch_state_e;

    localparam int DEF_NUM_CH    = 3;
    localparam int DEF_PER_W     = 16;
    localparam int DEF_POS_W     = 24;
    localparam int DEF_PULSE_W   = 8;
    localparam int DEF_DIR_SETUP = 4;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stepper_pulse_gen_if.sv
// Command handshake bundle: valid/ready transfer plus error strobe.
interface stepper_pulse_gen_if
    import stepper_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int PER_W  = DEF_PER_W
);
    localparam int CH_W = ch_w(NUM_CH);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [CH_W-1:0]  cmd_ch;
    logic             cmd_dir;
    logic [PER_W-1:0] cmd_period;
    logic             cmd_err;

    modport master (
        output cmd_valid, cmd_ch, cmd_dir, cmd_period,
        input  cmd_ready, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_ch, cmd_dir, cmd_period,
        output cmd_ready, cmd_err
    );

endinterface

// File: rtl/stepper_channel.sv
// One stepper channel: pending/active command, step FSM, position counter.
module stepper_channel
    import stepper_pkg::*;
#(
    parameter int PER_W     = DEF_PER_W,
    parameter int POS_W     = DEF_POS_W,
    parameter int PULSE_W   = DEF_PULSE_W,
    parameter int DIR_SETUP = DEF_DIR_SETUP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             wr,
    input  logic             wr_dir,
    input  logic [PER_W-1:0] wr_per,
    input  logic             pos_clr,
    output logic             step_out,
    output logic             dir_out,
    output logic             busy,
    output logic [POS_W-1:0] position
);
    localparam int CNT_W = (PER_W > 9) ? PER_W : 9;
    localparam logic [CNT_W-1:0] MIN_PER = CNT_W'(PULSE_W + 1);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, eff_per;
    logic [PER_W-1:0] per_q, per_d, pend_per;
    logic             dir_q, dir_d, pend_dir, pend_v, load;

    assign eff_per = (CNT_W'(per_q) > MIN_PER) ? CNT_W'(per_q) : MIN_PER;
    assign busy    = (state_q != ST_IDLE) | pend_v;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        dir_d   = dir_q;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE: load = pend_v;
            ST_SETUP: begin
                if (cnt_q == CNT_W'(DIR_SETUP)) begin
                    state_d = ST_HIGH;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HIGH: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(PULSE_W))
                    state_d = ST_LOW;
            end
            ST_LOW: begin
                if (cnt_q == eff_per) begin
                    if (pend_v) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_HIGH;
                        cnt_d   = CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            per_d = pend_per;
            cnt_d = CNT_W'(1);
            if (pend_per == '0) begin
                state_d = ST_IDLE;
            end else if (pend_dir != dir_q) begin
                state_d = ST_SETUP;
                dir_d   = pend_dir;
            end else begin
                state_d = ST_HIGH;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
            dir_q   <= 1'b0;
        end else if (clk_en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            dir_q   <= dir_d;
        end
    end

    // A write landing on the same edge as a load becomes the next pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_v   <= 1'b0;
            pend_dir <= 1'b0;
            pend_per <= '0;
        end else if (clk_en) begin
            if (wr) begin
                pend_v   <= 1'b1;
                pend_dir <= wr_dir;
                pend_per <= wr_per;
            end else if (load) begin
                pend_v <= 1'b0;
            end
        end
    end

    // Outputs are registered one edge behind the FSM state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_out <= 1'b0;
            dir_out  <= 1'b0;
            position <= '0;
        end else if (clk_en) begin
            step_out <= (state_q == ST_HIGH);
            dir_out  <= dir_q;
            if (pos_clr)
                position <= '0;
            else if (state_q == ST_HIGH && cnt_q == CNT_W'(1))
                position <= dir_q ? position + 1'b1 : position - 1'b1;
        end
    end

endmodule

// File: rtl/stepper_pulse_gen.sv
// Multi-channel stepper pulse generator: command decode and channel array.
module stepper_pulse_gen
    import stepper_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int PER_W     = DEF_PER_W,
    parameter int POS_W     = DEF_POS_W,
    parameter int PULSE_W   = DEF_PULSE_W,
    parameter int DIR_SETUP = DEF_DIR_SETUP
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_en,
    stepper_pulse_gen_if.slave      cmd,
    input  logic [NUM_CH-1:0]       pos_clr,
    output logic [NUM_CH-1:0]       step_out,
    output logic [NUM_CH-1:0]       dir_out,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH*POS_W-1:0] position
);
    localparam int CH_W = ch_w(NUM_CH);

    logic fire;
    logic bad_ch;

    assign cmd.cmd_ready = reset & clk_en;
    assign fire          = cmd.cmd_valid & cmd.cmd_ready;
    assign bad_ch        = int'(cmd.cmd_ch) >= NUM_CH;
    assign cmd.cmd_err   = fire & bad_ch;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        stepper_channel #(
            .PER_W     (PER_W),
            .POS_W     (POS_W),
            .PULSE_W   (PULSE_W),
            .DIR_SETUP (DIR_SETUP)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .clk_en   (clk_en),
            .wr       (fire && (cmd.cmd_ch == CH_W'(i))),
            .wr_dir   (cmd.cmd_dir),
            .wr_per   (cmd.cmd_period),
            .pos_clr  (pos_clr[i]),
            .step_out (step_out[i]),
            .dir_out  (dir_out[i]),
            .busy     (busy[i]),
            .position (position[i*POS_W +: POS_W])
        );
    end

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Self-checking bench for stepper_pulse_gen: vector table, corner sequences, random trials.
module tb_stepper_pulse_gen;
    localparam int NUM_CH    = 3;
    localparam int PER_W     = 16;
    localparam int POS_W     = 24;
    localparam int PULSE_W   = 8;
    localparam int DIR_SETUP = 4;

    typedef struct {
        int ch;
        int dir;
        int per;
        int lat;
        int intv;
    } vec_t;

    logic                    clk;
    logic                    reset;
    logic                    clk_en;
    logic [NUM_CH-1:0]       pos_clr;
    logic [NUM_CH-1:0]       step_out;
    logic [NUM_CH-1:0]       dir_out;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH*POS_W-1:0] position;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [POS_W-1:0] mpos [NUM_CH];
    logic [NUM_CH-1:0] mdir;

    stepper_pulse_gen_if #(.NUM_CH(NUM_CH), .PER_W(PER_W)) cif ();

    stepper_pulse_gen #(
        .NUM_CH    (NUM_CH),
        .PER_W     (PER_W),
        .POS_W     (POS_W),
        .PULSE_W   (PULSE_W),
        .DIR_SETUP (DIR_SETUP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clk_en   (clk_en),
        .cmd      (cif),
        .pos_clr  (pos_clr),
        .step_out (step_out),
        .dir_out  (dir_out),
        .busy     (busy),
        .position (position)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int eff(input int per);
        return (per > PULSE_W) ? per : PULSE_W + 1;
    endfunction

    function automatic int pos_of(input int ch);
        return int'(position[ch*POS_W +: POS_W]);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b0;
        clk_en        = 1'b1;
        pos_clr       = '0;
        cif.cmd_valid = 1'b0;
        #1;
        chk("rst_step", int'(step_out), 0);
        chk("rst_dir", int'(dir_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pos_nonzero", int'(position != '0), 0);
        chk("rst_ready", int'(cif.cmd_ready), 0);
        chk("rst_err", int'(cif.cmd_err), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mdir  = '0;
        for (int i = 0; i < NUM_CH; i++) mpos[i] = '0;
    endtask

    task automatic send(input int ch, input int dir, input int per);
        @(negedge clk);
        cif.cmd_valid  = 1'b1;
        cif.cmd_ch     = 2'(ch);
        cif.cmd_dir    = dir[0];
        cif.cmd_period = PER_W'(per);
        @(negedge clk);
        cif.cmd_valid = 1'b0;
    endtask

    task automatic watch(input int ch, input int t_ref, input int first,
                         input int intv, input int dir, input int nr,
                         output int t_last);
        int   k;
        int   budget;
        int   t_prev;
        logic prev;
        k      = 0;
        t_prev = t_ref;
        prev   = step_out[ch];
        budget = first + intv * nr + 30;
        while (k < nr && budget > 0) begin
            @(negedge clk);
            budget--;
            if (step_out[ch] && !prev) begin
                if (k == 0) chk("first_rise", cyc - t_prev, first);
                else        chk("rise_interval", cyc - t_prev, intv);
                chk("dir_at_rise", int'(dir_out[ch]), dir);
                mpos[ch] = (dir != 0) ? mpos[ch] + 1'b1 : mpos[ch] - 1'b1;
                chk("position", pos_of(ch), int'(mpos[ch]));
                t_prev = cyc;
                k++;
            end else if (!step_out[ch] && prev) begin
                chk("high_time", cyc - t_prev, PULSE_W);
            end
            prev = step_out[ch];
        end
        if (k < nr) chk("rise_timeout_rises_seen", k, nr);
        t_last = t_prev;
    endtask

    task automatic stop_ch(input int ch, input int t_last, input int e);
        int   budget;
        int   extra;
        logic prev;
        budget = e + 30;
        extra  = 0;
        send(ch, 0, 0);
        prev = step_out[ch];
        while (busy[ch] && budget > 0) begin
            @(negedge clk);
            budget--;
            if (step_out[ch] && !prev) extra++;
            if (!step_out[ch] && prev) chk("stop_high_time", cyc - t_last, PULSE_W);
            prev = step_out[ch];
        end
        chk("stop_idle_time", cyc - t_last, e - 1);
        chk("rise_after_stop", extra, 0);
        chk("stop_pos", pos_of(ch), int'(mpos[ch]));
    endtask

    vec_t tbl[7];
    int   t;
    int   tl;
    int   budget;

    initial begin
        reset          = 1'b0;
        clk_en         = 1'b1;
        pos_clr        = '0;
        cif.cmd_valid  = 1'b0;
        cif.cmd_ch     = '0;
        cif.cmd_dir    = 1'b0;
        cif.cmd_period = '0;

        tbl[0] = '{0, 1, 20, 6, 20};
        tbl[1] = '{1, 0, 3,  2, 9};
        tbl[2] = '{2, 1, 9,  6, 9};
        tbl[3] = '{0, 0, 10, 2, 10};
        tbl[4] = '{1, 1, 1,  6, 9};
        tbl[5] = '{2, 0, 40, 2, 40};
        tbl[6] = '{0, 1, 8,  6, 9};

        for (int i = 0; i < 7; i++) begin
            do_reset();
            send(tbl[i].ch, tbl[i].dir, tbl[i].per);
            t = cyc;
            watch(tbl[i].ch, t, tbl[i].lat, tbl[i].intv, tbl[i].dir, 3, tl);
            stop_ch(tbl[i].ch, tl, tbl[i].intv);
        end

        // Reversal while running.
        do_reset();
        send(0, 1, 20);
        t = cyc;
        watch(0, t, 6, 20, 1, 2, tl);
        send(0, 0, 20);
        watch(0, tl, 20 + DIR_SETUP, 20, 0, 3, tl);
        stop_ch(0, tl, 20);

        // Last write wins.
        do_reset();
        send(2, 0, 20);
        t = cyc;
        watch(2, t, 2, 20, 0, 1, tl);
        send(2, 0, 30);
        send(2, 0, 50);
        watch(2, tl, 20, 50, 0, 3, tl);
        stop_ch(2, tl, 50);

        // Position clear coinciding with a step edge.
        do_reset();
        send(1, 1, 10);
        t = cyc;
        watch(1, t, 6, 10, 1, 1, tl);
        repeat (9) @(negedge clk);
        pos_clr[1] = 1'b1;
        @(negedge clk);
        pos_clr[1] = 1'b0;
        chk("clr_step_rose", int'(step_out[1]), 1);
        chk("clr_wins", pos_of(1), 0);
        mpos[1] = '0;
        watch(1, tl + 10, 10, 10, 1, 2, tl);
        stop_ch(1, tl, 10);

        // Bad channel.
        @(negedge clk);
        cif.cmd_valid  = 1'b1;
        cif.cmd_ch     = 2'd3;
        cif.cmd_dir    = 1'b1;
        cif.cmd_period = 16'd5;
        #1;
        chk("err_ready", int'(cif.cmd_ready), 1);
        chk("err_pulse", int'(cif.cmd_err), 1);
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        #1;
        chk("err_clear", int'(cif.cmd_err), 0);
        repeat (3) @(negedge clk);
        chk("err_busy", int'(busy), 0);
        chk("err_step", int'(step_out), 0);
        chk("err_pos1", pos_of(1), int'(mpos[1]));

        // Freeze mid-HIGH, then async reset mid-HIGH.
        do_reset();
        send(0, 1, 20);
        t = cyc;
        watch(0, t, 6, 20, 1, 1, tl);
        repeat (2) @(negedge clk);
        clk_en         = 1'b0;
        cif.cmd_valid  = 1'b1;
        cif.cmd_ch     = 2'd3;
        cif.cmd_period = 16'd7;
        #1;
        chk("frz_ready", int'(cif.cmd_ready), 0);
        chk("frz_err", int'(cif.cmd_err), 0);
        repeat (10) @(negedge clk);
        chk("frz_step_held", int'(step_out[0]), 1);
        chk("frz_pos_held", pos_of(0), int'(mpos[0]));
        clk_en        = 1'b1;
        cif.cmd_valid = 1'b0;
        budget = 40;
        while (step_out[0] && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("frz_high_time", cyc - tl, PULSE_W + 10);
        watch(0, tl, 30, 20, 1, 1, tl);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("arst_step", int'(step_out[0]), 0);
        chk("arst_pos", pos_of(0), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_dir", int'(dir_out), 0);
        @(negedge clk);
        reset = 1'b1;

        // Random single-channel trials against the arithmetic model.
        do_reset();
        for (int n = 0; n < 14; n++) begin
            int ch, dir, per, lat;
            ch  = $urandom_range(0, NUM_CH - 1);
            dir = $urandom_range(0, 1);
            per = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 35);
            send(ch, dir, per);
            t = cyc;
            if (per == 0) begin
                budget = 10;
                while (busy[ch] && budget > 0) begin
                    @(negedge clk);
                    budget--;
                end
                chk("rnd_stop_idle", cyc - t, 1);
                chk("rnd_stop_pos", pos_of(ch), int'(mpos[ch]));
                chk("rnd_stop_step", int'(step_out[ch]), 0);
            end else begin
                lat = 2 + ((dir[0] != mdir[ch]) ? DIR_SETUP : 0);
                watch(ch, t, lat, eff(per), dir, 2, tl);
                stop_ch(ch, tl, eff(per));
                mdir[ch] = dir[0];
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
